// File: rtl/riscv_ctrl_pkg.sv
// Shared types for the decode/control stage: ALU/MDU operation codes,
// immediate and result selectors, opcode constants, the decoded control
// bundle, and a helper that identifies divide-class operations.
package riscv_ctrl_pkg;

  typedef enum logic [4:0] {
    ALU_ADD    = 5'd0,
    ALU_SUB    = 5'd1,
    ALU_SLL    = 5'd2,
    ALU_SLT    = 5'd3,
    ALU_SLTU   = 5'd4,
    ALU_XOR    = 5'd5,
    ALU_SRL    = 5'd6,
    ALU_SRA    = 5'd7,
    ALU_OR     = 5'd8,
    ALU_AND    = 5'd9,
    ALU_LUI    = 5'd10,
    ALU_MUL    = 5'd11,
    ALU_MULH   = 5'd12,
    ALU_MULHSU = 5'd13,
    ALU_MULHU  = 5'd14,
    ALU_DIV    = 5'd15,
    ALU_DIVU   = 5'd16,
    ALU_REM    = 5'd17,
    ALU_REMU   = 5'd18
  } alu_op_e;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_J = 3'b011,
    IMM_U = 3'b100
  } imm_src_e;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } result_src_e;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I_ALU  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef struct packed {
    logic        reg_write;
    result_src_e result_src;
    logic        mem_write;
    logic        jump;
    logic        branch;
    logic        alu_src_a;
    logic        alu_src_b;
    imm_src_e    imm_src;
    alu_op_e     alu_op;
  } ctrl_t;

  function automatic logic is_div(alu_op_e op);
    return (op == ALU_DIV) || (op == ALU_DIVU) || (op == ALU_REM) || (op == ALU_REMU);
  endfunction

endpackage

// File: rtl/rv_decode_logic.sv
// Purely combinational RV32I(+M) decoder.
// Ports:
//   instr   - raw 32-bit instruction
//   ctrl    - decoded control bundle (all zero for illegal encodings)
//   illegal - encoding is not a supported instruction
module rv_decode_logic
  import riscv_ctrl_pkg::*;
#(
  parameter int EN_M = 1
) (
  input  logic [31:0] instr,
  output ctrl_t       ctrl,
  output logic        illegal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  // Register and immediate fields are consumed by the register file and
  // immediate generator, not by control decode.
  logic unused_reg_fields;
  assign unused_reg_fields = ^{instr[24:15], instr[11:7]};

  always_comb begin
    ctrl    = '0;
    illegal = 1'b0;
    case (opcode)
      OPC_R: begin
        ctrl.reg_write = 1'b1;
        if (funct7 == 7'b0000000) begin
          case (funct3)
            3'd0:    ctrl.alu_op = ALU_ADD;
            3'd1:    ctrl.alu_op = ALU_SLL;
            3'd2:    ctrl.alu_op = ALU_SLT;
            3'd3:    ctrl.alu_op = ALU_SLTU;
            3'd4:    ctrl.alu_op = ALU_XOR;
            3'd5:    ctrl.alu_op = ALU_SRL;
            3'd6:    ctrl.alu_op = ALU_OR;
            default: ctrl.alu_op = ALU_AND;
          endcase
        end else if (funct7 == 7'b0100000 && funct3 == 3'd0) begin
          ctrl.alu_op = ALU_SUB;
        end else if (funct7 == 7'b0100000 && funct3 == 3'd5) begin
          ctrl.alu_op = ALU_SRA;
        end else if (funct7 == 7'b0000001 && EN_M != 0) begin
          case (funct3)
            3'd0:    ctrl.alu_op = ALU_MUL;
            3'd1:    ctrl.alu_op = ALU_MULH;
            3'd2:    ctrl.alu_op = ALU_MULHSU;
            3'd3:    ctrl.alu_op = ALU_MULHU;
            3'd4:    ctrl.alu_op = ALU_DIV;
            3'd5:    ctrl.alu_op = ALU_DIVU;
            3'd6:    ctrl.alu_op = ALU_REM;
            default: ctrl.alu_op = ALU_REMU;
          endcase
        end else begin
          illegal = 1'b1;
        end
      end
      OPC_I_ALU: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src_b = 1'b1;
        ctrl.imm_src   = IMM_I;
        case (funct3)
          3'd0: ctrl.alu_op = ALU_ADD;
          3'd1: begin
            if (funct7 == 7'b0000000) ctrl.alu_op = ALU_SLL;
            else                      illegal = 1'b1;
          end
          3'd2: ctrl.alu_op = ALU_SLT;
          3'd3: ctrl.alu_op = ALU_SLTU;
          3'd4: ctrl.alu_op = ALU_XOR;
          3'd5: begin
            if (funct7 == 7'b0000000)      ctrl.alu_op = ALU_SRL;
            else if (funct7 == 7'b0100000) ctrl.alu_op = ALU_SRA;
            else                           illegal = 1'b1;
          end
          3'd6:    ctrl.alu_op = ALU_OR;
          default: ctrl.alu_op = ALU_AND;
        endcase
      end
      OPC_LOAD: begin
        ctrl.reg_write  = 1'b1;
        ctrl.result_src = RES_MEM;
        ctrl.alu_src_b  = 1'b1;
        ctrl.imm_src    = IMM_I;
        ctrl.alu_op     = ALU_ADD;
        // LB/LH/LW/LBU/LHU only
        if (funct3 == 3'd3 || funct3 == 3'd6 || funct3 == 3'd7) illegal = 1'b1;
      end
      OPC_STORE: begin
        ctrl.mem_write = 1'b1;
        ctrl.alu_src_b = 1'b1;
        ctrl.imm_src   = IMM_S;
        ctrl.alu_op    = ALU_ADD;
        if (funct3 > 3'd2) illegal = 1'b1;
      end
      OPC_BRANCH: begin
        ctrl.branch  = 1'b1;
        ctrl.imm_src = IMM_B;
        ctrl.alu_op  = ALU_SUB;
        if (funct3 == 3'd2 || funct3 == 3'd3) illegal = 1'b1;
      end
      OPC_JAL: begin
        ctrl.reg_write  = 1'b1;
        ctrl.result_src = RES_PC4;
        ctrl.jump       = 1'b1;
        ctrl.imm_src    = IMM_J;
        ctrl.alu_op     = ALU_ADD;
      end
      OPC_JALR: begin
        ctrl.reg_write  = 1'b1;
        ctrl.result_src = RES_PC4;
        ctrl.jump       = 1'b1;
        ctrl.alu_src_b  = 1'b1;
        ctrl.imm_src    = IMM_I;
        ctrl.alu_op     = ALU_ADD;
        if (funct3 != 3'd0) illegal = 1'b1;
      end
      OPC_LUI: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src_b = 1'b1;
        ctrl.imm_src   = IMM_U;
        ctrl.alu_op    = ALU_LUI;
      end
      OPC_AUIPC: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 1'b1;
        ctrl.imm_src   = IMM_U;
        ctrl.alu_op    = ALU_ADD;
      end
      default: illegal = 1'b1;
    endcase
    // An illegal entry carries no side effects downstream.
    if (illegal) ctrl = '0;
  end

endmodule

// File: rtl/decode_ctrl_stage.sv
// Registered decode/control stage between fetch and execute.
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   flush_i               - discard output entry and abort divide interlock
//   in_valid_i/in_ready_o - fetch-side handshake, instr_i is the payload
//   out_valid_o/out_ready_i - execute-side handshake for the control entry
//   reg_write_o .. alu_ctrl_o - registered decoded controls
//   illegal_o             - entry holds an illegal instruction
//   md_busy_o             - divide interlock active
//
// state | meaning
// IDLE  | normal operation, accepts when the output slot frees up
// BUSY  | divide in flight downstream, input blocked until counter hits 0
module decode_ctrl_stage
  import riscv_ctrl_pkg::*;
#(
  parameter int EN_M       = 1,
  parameter int ALU_CTRL_W = 5,
  parameter int DIV_CYCLES = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [31:0]           instr_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic                  reg_write_o,
  output logic [1:0]            result_src_o,
  output logic                  mem_write_o,
  output logic                  jump_o,
  output logic                  branch_o,
  output logic                  alu_src_a_o,
  output logic                  alu_src_b_o,
  output logic [2:0]            imm_src_o,
  output logic [ALU_CTRL_W-1:0] alu_ctrl_o,
  output logic                  illegal_o,
  output logic                  md_busy_o
);

  localparam int CNT_W = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;

  typedef enum logic {ST_IDLE, ST_BUSY} state_e;

  state_e             state, state_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  ctrl_t              dec_ctrl, ctrl_q;
  logic               dec_illegal, illegal_q;
  logic               out_valid_q;
  logic               accept, out_xfer;

  rv_decode_logic #(.EN_M(EN_M)) u_decode (
    .instr   (instr_i),
    .ctrl    (dec_ctrl),
    .illegal (dec_illegal)
  );

  assign in_ready_o = !flush_i && (state == ST_IDLE) && (!out_valid_q || out_ready_i);
  assign accept     = in_valid_i && in_ready_o;
  // Flush discards the entry, so a same-cycle consume does not count.
  assign out_xfer   = out_valid_q && out_ready_i && !flush_i;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      out_valid_q <= 1'b0;
      ctrl_q      <= '0;
      illegal_q   <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      if (flush_i) begin
        out_valid_q <= 1'b0;
      end else if (accept) begin
        out_valid_q <= 1'b1;
        ctrl_q      <= dec_ctrl;
        illegal_q   <= dec_illegal;
      end else if (out_xfer) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    if (flush_i) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (out_xfer && is_div(ctrl_q.alu_op)) begin
            state_d = ST_BUSY;
            cnt_d   = CNT_W'(DIV_CYCLES - 1);
          end
        end
        default: begin
          if (cnt == '0) state_d = ST_IDLE;
          else           cnt_d   = cnt - CNT_W'(1);
        end
      endcase
    end
  end

  assign out_valid_o  = out_valid_q;
  assign reg_write_o  = ctrl_q.reg_write;
  assign result_src_o = ctrl_q.result_src;
  assign mem_write_o  = ctrl_q.mem_write;
  assign jump_o       = ctrl_q.jump;
  assign branch_o     = ctrl_q.branch;
  assign alu_src_a_o  = ctrl_q.alu_src_a;
  assign alu_src_b_o  = ctrl_q.alu_src_b;
  assign imm_src_o    = ctrl_q.imm_src;
  assign alu_ctrl_o   = ALU_CTRL_W'(ctrl_q.alu_op);
  assign illegal_o    = illegal_q;
  assign md_busy_o    = (state == ST_BUSY);

endmodule

// File: tb/tb_decode_ctrl_stage.sv
module tb_decode_ctrl_stage;

  // expected vector: {illegal, reg_write, result_src[1:0], mem_write, jump, branch, src_a, src_b, imm[2:0], alu[4:0]}
  localparam logic [16:0] E_ADD   = {1'b0, 1'b1, 2'b00, 5'b00000, 3'b000, 5'd0};
  localparam logic [16:0] E_SUB   = {1'b0, 1'b1, 2'b00, 5'b00000, 3'b000, 5'd1};
  localparam logic [16:0] E_LW    = {1'b0, 1'b1, 2'b01, 5'b00001, 3'b000, 5'd0};
  localparam logic [16:0] E_SW    = {1'b0, 1'b0, 2'b00, 5'b10001, 3'b001, 5'd0};
  localparam logic [16:0] E_BEQ   = {1'b0, 1'b0, 2'b00, 5'b00100, 3'b010, 5'd1};
  localparam logic [16:0] E_JAL   = {1'b0, 1'b1, 2'b10, 5'b01000, 3'b011, 5'd0};
  localparam logic [16:0] E_JALR  = {1'b0, 1'b1, 2'b10, 5'b01001, 3'b000, 5'd0};
  localparam logic [16:0] E_LUI   = {1'b0, 1'b1, 2'b00, 5'b00001, 3'b100, 5'd10};
  localparam logic [16:0] E_AUIPC = {1'b0, 1'b1, 2'b00, 5'b00011, 3'b100, 5'd0};
  localparam logic [16:0] E_SRAI  = {1'b0, 1'b1, 2'b00, 5'b00001, 3'b000, 5'd7};
  localparam logic [16:0] E_MUL   = {1'b0, 1'b1, 2'b00, 5'b00000, 3'b000, 5'd11};
  localparam logic [16:0] E_DIV   = {1'b0, 1'b1, 2'b00, 5'b00000, 3'b000, 5'd15};
  localparam logic [16:0] E_ILL   = {1'b1, 1'b0, 2'b00, 5'b00000, 3'b000, 5'd0};

  localparam logic [31:0] I_ADD   = 32'h002081B3;
  localparam logic [31:0] I_SUB   = 32'h402081B3;
  localparam logic [31:0] I_LW    = 32'h0040A283;
  localparam logic [31:0] I_SW    = 32'h0020A423;
  localparam logic [31:0] I_BEQ   = 32'h00208063;
  localparam logic [31:0] I_JAL   = 32'h000000EF;
  localparam logic [31:0] I_JALR  = 32'h00008067;
  localparam logic [31:0] I_LUI   = 32'h123452B7;
  localparam logic [31:0] I_AUIPC = 32'h00001297;
  localparam logic [31:0] I_SRAI  = 32'h40315093;
  localparam logic [31:0] I_MUL   = 32'h023100B3;
  localparam logic [31:0] I_DIV   = 32'h0231C0B3;
  localparam logic [31:0] I_BADR  = 32'h402091B3;
  localparam logic [31:0] I_BADSL = 32'h40311093;
  localparam logic [31:0] I_OP7F  = 32'h0000007F;

  logic        clk = 1'b0;
  logic        reset = 1'b1, flush = 1'b0;
  logic        in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] instr = '0;
  logic        in_ready, out_valid, reg_write, mem_write, jump, branch;
  logic        alu_src_a, alu_src_b, illegal, md_busy;
  logic [1:0]  result_src;
  logic [2:0]  imm_src;
  logic [4:0]  alu_ctrl;
  logic [16:0] obs;

  logic        nm_in_valid = 1'b0, nm_out_ready = 1'b0;
  logic        nm_in_ready, nm_out_valid, nm_reg_write, nm_mem_write, nm_jump, nm_branch;
  logic        nm_alu_src_a, nm_alu_src_b, nm_illegal, nm_md_busy;
  logic [1:0]  nm_result_src;
  logic [2:0]  nm_imm_src;
  logic [3:0]  nm_alu_ctrl;

  int          checks = 0;
  int          errors = 0;
  logic [16:0] cur_exp = '0;
  logic [16:0] sb_q[$];

  always #5 clk = ~clk;

  assign obs = {illegal, reg_write, result_src, mem_write, jump, branch, alu_src_a, alu_src_b, imm_src, alu_ctrl};

  decode_ctrl_stage #(.EN_M(1), .ALU_CTRL_W(5), .DIV_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .instr_i(instr), .out_valid_o(out_valid), .out_ready_i(out_ready), .reg_write_o(reg_write),
    .result_src_o(result_src), .mem_write_o(mem_write), .jump_o(jump), .branch_o(branch),
    .alu_src_a_o(alu_src_a), .alu_src_b_o(alu_src_b), .imm_src_o(imm_src), .alu_ctrl_o(alu_ctrl),
    .illegal_o(illegal), .md_busy_o(md_busy)
  );

  decode_ctrl_stage #(.EN_M(0), .ALU_CTRL_W(4), .DIV_CYCLES(4)) dut_nm (
    .clk(clk), .reset(reset), .flush_i(flush), .in_valid_i(nm_in_valid), .in_ready_o(nm_in_ready),
    .instr_i(instr), .out_valid_o(nm_out_valid), .out_ready_i(nm_out_ready), .reg_write_o(nm_reg_write),
    .result_src_o(nm_result_src), .mem_write_o(nm_mem_write), .jump_o(nm_jump), .branch_o(nm_branch),
    .alu_src_a_o(nm_alu_src_a), .alu_src_b_o(nm_alu_src_b), .imm_src_o(nm_imm_src), .alu_ctrl_o(nm_alu_ctrl),
    .illegal_o(nm_illegal), .md_busy_o(nm_md_busy)
  );

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Scoreboard: push on accept, pop on output transfer; a flush drops the held entry.
  task automatic sb_monitor();
    logic [16:0] e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (flush) begin
          if (out_valid && sb_q.size() > 0) void'(sb_q.pop_front());
        end else begin
          if (out_valid && out_ready) begin
            checks++;
            if (sb_q.size() == 0) begin
              errors++;
              $display("FAIL sb_unexpected: got entry %h, expected none", obs);
            end else begin
              e = sb_q.pop_front();
              if (e[16]) begin
                if ({obs[16], obs[15], obs[12:10]} !== {e[16], e[15], e[12:10]}) begin
                  errors++;
                  $display("FAIL sb_illegal: got %h, expected illegal fields of %h", obs, e);
                end
              end else if (obs !== e) begin
                errors++;
                $display("FAIL sb_ctrl: got %h, expected %h", obs, e);
              end
            end
          end
          if (in_valid && in_ready) sb_q.push_back(cur_exp);
        end
      end
    end
  endtask

  task automatic send(input logic [31:0] ins, input logic [16:0] e, output int n);
    n        = 0;
    in_valid = 1'b1;
    instr    = ins;
    cur_exp  = e;
    @(negedge clk);
    while (in_ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (in_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: instr %h in_ready=%b, expected 1", ins, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset(input bit loaded);
    int n;
    if (loaded) begin
      out_ready = 1'b0;
      send(I_ADD, E_ADD, n);
    end
    reset = 1'b1;
    flush = loaded;
    repeat (2) @(posedge clk);
    #1;
    sb_q.delete();
    reset     = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || nm_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid: out_valid=%b nm_out_valid=%b, expected 0 0", out_valid, nm_out_valid);
    end
    checks++;
    if (obs !== 17'd0) begin
      errors++;
      $display("FAIL reset_ctrl: got %h, expected 0", obs);
    end
    checks++;
    if (md_busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_fsm: md_busy=%b in_ready=%b, expected 0 1", md_busy, in_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_add_latency();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    instr     = I_ADD;
    cur_exp   = E_ADD;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL add_accept: in_ready=%b out_valid=%b, expected 1 0", in_ready, out_valid);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || alu_ctrl !== 5'd0 || reg_write !== 1'b1) begin
      errors++;
      $display("FAIL add_latency: out_valid=%b alu=%0d reg_write=%b, expected 1 0 1", out_valid, alu_ctrl, reg_write);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_decode_stream();
    logic [31:0] it[14];
    logic [16:0] et[14];
    int n;
    it = '{I_ADD, I_SUB, I_LW, I_SW, I_BEQ, I_JAL, I_JALR, I_LUI, I_AUIPC, I_SRAI, I_MUL, I_BADR, I_BADSL, I_OP7F};
    et = '{E_ADD, E_SUB, E_LW, E_SW, E_BEQ, E_JAL, E_JALR, E_LUI, E_AUIPC, E_SRAI, E_MUL, E_ILL, E_ILL, E_ILL};
    out_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      send(it[i], et[i], n);
      checks++;
      if (n != 0) begin
        errors++;
        $display("FAIL back_to_back: instr %h waited %0d cycles, expected 0", it[i], n);
      end
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_stall();
    int n;
    out_ready = 1'b0;
    send(I_ADD, E_ADD, n);
    in_valid = 1'b1;
    instr    = I_SUB;
    cur_exp  = E_SUB;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || obs !== E_ADD) begin
        errors++;
        $display("FAIL stall_hold: cycle %0d in_ready=%b out_valid=%b ctrl=%h, expected 0 1 %h", i, in_ready, out_valid, obs, E_ADD);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    send(I_SUB, E_SUB, n);
    send(I_LUI, E_LUI, n);
    send(I_LW, E_LW, n);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL stall_drain: %0d entries outstanding, expected 0", sb_q.size());
    end
  endtask

  task automatic test_div_interlock();
    int n;
    out_ready = 1'b1;
    send(I_DIV, E_DIV, n);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || md_busy !== 1'b0) begin
      errors++;
      $display("FAIL div_pre: out_valid=%b md_busy=%b, expected 1 0", out_valid, md_busy);
    end
    @(posedge clk); #1;
    in_valid = 1'b1;
    instr    = I_ADD;
    cur_exp  = E_ADD;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (md_busy !== 1'b1 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL div_busy: cycle %0d md_busy=%b in_ready=%b, expected 1 0", i, md_busy, in_ready);
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    checks++;
    if (md_busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL div_release: md_busy=%b in_ready=%b, expected 0 1", md_busy, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    send(I_MUL, E_MUL, n);
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (md_busy !== 1'b0) begin
      errors++;
      $display("FAIL mul_no_interlock: md_busy=%b, expected 0", md_busy);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_flush();
    int n;
    out_ready = 1'b1;
    send(I_DIV, E_DIV, n);
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (md_busy !== 1'b1) begin
      errors++;
      $display("FAIL flush_setup: md_busy=%b, expected 1", md_busy);
    end
    @(posedge clk); #1;
    in_valid = 1'b1;
    instr    = I_ADD;
    cur_exp  = E_ADD;
    flush    = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_busy_ready: in_ready=%b, expected 0", in_ready);
    end
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    checks++;
    if (md_busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_busy_abort: md_busy=%b out_valid=%b, expected 0 0", md_busy, out_valid);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(I_SUB, E_SUB, n);
    in_valid = 1'b1;
    instr    = I_LUI;
    cur_exp  = E_LUI;
    flush    = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_entry_ready: in_ready=%b, expected 0", in_ready);
    end
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_entry_drop: out_valid=%b, expected 0", out_valid);
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_no_m();
    logic [31:0] it[3];
    it = '{I_MUL, I_OP7F, I_DIV};
    nm_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      nm_in_valid = 1'b1;
      instr       = it[i];
      @(negedge clk);
      checks++;
      if (nm_in_ready !== 1'b1) begin
        errors++;
        $display("FAIL nm_accept: instr %h in_ready=%b, expected 1", it[i], nm_in_ready);
      end
      @(posedge clk); #1;
      nm_in_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (nm_out_valid !== 1'b1 || nm_illegal !== 1'b1 || nm_reg_write !== 1'b0) begin
        errors++;
        $display("FAIL nm_illegal: instr %h out_valid=%b illegal=%b reg_write=%b, expected 1 1 0", it[i], nm_out_valid, nm_illegal, nm_reg_write);
      end
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (nm_md_busy !== 1'b0) begin
        errors++;
        $display("FAIL nm_busy: instr %h md_busy=%b, expected 0", it[i], nm_md_busy);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    fork
      sb_monitor();
    join_none
    test_reset(1'b0);
    test_add_latency();
    test_decode_stream();
    test_stall();
    test_div_interlock();
    test_flush();
    test_no_m();
    test_reset(1'b1);
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: %0d entries outstanding, expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
